// File: rtl/press_counter.sv
// press_counter: press-event detector with decimal (BCD) press count and auto-repeat.
// Sits after the debouncer. It counts rising edges of the debounced level. A held
// switch counts again after HOLD_CYCLES, then once every REPEAT_CYCLES.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   db     in   debounced switch level (1 = pressed), synchronous to clk
//   clr    in   synchronous count clear; overrides a coincident increment
//   bcd    out  4*DIGITS-bit BCD count, digit 0 in bits [3:0]
//   inc    out  one-cycle strobe after every increment
//   wrap   out  one-cycle strobe after all-nines rolls to zero
//   state  out  FSM state for debug: 0 IDLE, 1 PRESSED, 2 REPEAT
module press_counter #(
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned HOLD_CYCLES   = 20,
  parameter int unsigned REPEAT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  db,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  inc,
  output logic                  wrap,
  output logic [1:0]            state
);

  localparam int unsigned BW   = 4 * DIGITS;
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   t_q;
  logic            db_prev_q;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   bcd_d;
  logic            inc_q;
  logic            wrap_q;
  logic            carry_out_c;
  logic            inc_ev_c;

  // Increment event for this edge; never on a release edge because db must be 1.
  always_comb begin
    inc_ev_c = 1'b0;
    unique case (state_q)
      IDLE:    inc_ev_c = db && !db_prev_q;
      PRESSED: inc_ev_c = db && (t_q == TW'(HOLD_CYCLES - 1));
      REPEAT:  inc_ev_c = db && (t_q == TW'(REPEAT_CYCLES - 1));
      default: inc_ev_c = 1'b0;
    endcase
  end

  // Ripple BCD increment; a carry out of the top digit means all-nines rolled over.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    bcd_d = bcd_q;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          bcd_d[4*i +: 4] = 4'd0;
        end else begin
          bcd_d[4*i +: 4] = digit + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    carry_out_c = carry;
  end

  // FSM, timer and count; clr only touches the count path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      t_q       <= '0;
      db_prev_q <= 1'b1;  // a switch held across reset release is not a new press
      bcd_q     <= '0;
      inc_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      db_prev_q <= db;
      inc_q     <= 1'b0;
      wrap_q    <= 1'b0;

      if (clr) begin
        bcd_q <= '0;
      end else if (inc_ev_c) begin
        bcd_q  <= bcd_d;
        inc_q  <= 1'b1;
        wrap_q <= carry_out_c;
      end

      unique case (state_q)
        IDLE: begin
          if (db && !db_prev_q) begin
            state_q <= PRESSED;
            t_q     <= '0;
          end
        end
        PRESSED: begin
          if (!db) begin
            state_q <= IDLE;
            t_q     <= '0;
          end else if (t_q == TW'(HOLD_CYCLES - 1)) begin
            state_q <= REPEAT;
            t_q     <= '0;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        REPEAT: begin
          if (!db) begin
            state_q <= IDLE;
            t_q     <= '0;
          end else if (t_q == TW'(REPEAT_CYCLES - 1)) begin
            t_q <= '0;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          t_q     <= '0;
        end
      endcase
    end
  end

  assign bcd   = bcd_q;
  assign inc   = inc_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule

// File: doc/press_counter.md
# press_counter

Consumer stage placed directly after the debouncer. Takes the clean, debounced switch level, detects press events and keeps a decimal (BCD) count of presses for the display numerator. Holding the switch past a hold threshold enters auto-repeat and increments at a fixed rate. A one-cycle increment strobe and a wrap flag are also produced for downstream logic.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits in the count (1..4)
- HOLD_CYCLES, 20, cycles the switch must stay pressed after the first increment before auto-repeat starts (>=2)
- REPEAT_CYCLES, 5, cycles between auto-repeat increments (>=2)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- db  in  1  debounced switch level from the debouncer; 1 = pressed; synchronous to clk
- clr  in  1  synchronous clear of the count, active-high
- bcd  out  4*DIGITS  count; digit i occupies bits [4i+3:4i], digit 0 is least significant
- inc  out  1  one-cycle strobe, high in the cycle after every increment
- wrap  out  1  one-cycle strobe, high in the cycle after the count rolls from all-nines to zero
- state  out  2  current FSM state for debug: 0 IDLE, 1 PRESSED, 2 REPEAT

## Operation
- Registers: `db_prev`, the FSM state, timer `t` (wide enough for max(HOLD_CYCLES, REPEAT_CYCLES)-1), the BCD count, `inc` and `wrap`.
- Reset (reset = 0, asynchronous): bcd = 0, inc = 0, wrap = 0, state = IDLE, t = 0, db_prev = 1.
  - db_prev resets to 1 so a switch already held at reset release is not counted.
- `db_prev` is loaded with db on every edge.
- IDLE:
  - If db = 1 and db_prev = 0: increment, go to PRESSED, t = 0.
  - Otherwise stay in IDLE.
- PRESSED:
  - If db = 0: go to IDLE, t = 0, no increment.
  - Else if t = HOLD_CYCLES-1: increment, go to REPEAT, t = 0.
  - Else t = t+1.
- REPEAT:
  - If db = 0: go to IDLE, t = 0.
  - Else if t = REPEAT_CYCLES-1: increment, t = 0.
  - Else t = t+1.
- Increment is BCD:
  - Digit 0 is incremented. Any digit that was 9 becomes 0 and carries into the next digit.
  - All-nines becomes all-zeros, and wrap is asserted on that same edge.
  - Digit values 10..15 never occur.
- clr:
  - Sets bcd = 0 on the edge where it is sampled high.
  - Has priority over a coincident increment. In that case bcd = 0, inc = 0 and wrap = 0.
  - The FSM and timer still advance normally; clr does not affect them.
- inc and wrap are registered and are low on every edge without an increment or wrap.

## Timing
- Latency: db rises and is sampled at edge k (db_prev = 0). bcd holds the new value and inc = 1 during cycle k→k+1.
- Held switch, first sampled high at edge k and staying high:
  - Increments occur at edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, k+HOLD_CYCLES+2·REPEAT_CYCLES, and so on.
- Release:
  - db sampled 0 at any edge returns the FSM to IDLE at that edge.
  - No increment occurs at a release edge, even if t is at threshold.
- Re-press: a new rising edge one cycle after release (db 1,0,1) counts as a new press.
- Minimum spacing between two inc strobes is 2 cycles, guaranteed by the parameter minimums.
- Reset mid-press: outputs clear immediately and asynchronously. After release, a still-high db is ignored until it has been sampled 0.

## Test plan
- Reset release with db = 0, then db high for 3 cycles → bcd = 0x01, exactly one inc pulse, state returns to 0 one edge after db falls.
- Three separate 3-cycle presses with 4-cycle gaps → bcd = 0x03, three inc pulses, wrap never asserted.
- db high for 30 consecutive sampled edges starting at edge k (defaults) → increments at k, k+20, k+25; bcd = 0x03; state reaches 2 at edge k+20.
- Preload by 99 presses, then one more press → bcd = 0x00, inc and wrap both high for one cycle; next press → bcd = 0x01 with wrap low.
- Assert clr on the same edge as a press rising edge with bcd = 0x42 → bcd = 0x00, inc stays 0, state = PRESSED.
- Hold db = 1 through a mid-press reset pulse (reset = 0 for 2 cycles) → bcd = 0 immediately; no increment while db stays high; after db 0 then 1, bcd = 0x01.
